// File: rtl/mlp_sequencer.sv
// Two-layer fully connected inference sequencer: one signed MAC per clock,
// ReLU with saturation per neuron, hidden results buffered internally.
module mlp_sequencer #(
   parameter int WIDTH      = 4,
   parameter int WIDTH_W    = 9,
   parameter int LENGHT_I   = 2,
   parameter int LENGHT_MID = 2,
   parameter int LENGHT_O   = 2,
   parameter int SHIFT      = 0,
   parameter int N_W        = LENGHT_I * LENGHT_MID + LENGHT_MID * LENGHT_O,
   parameter int ACC_W      = WIDTH + WIDTH_W + 1 +
                              $clog2((LENGHT_I > LENGHT_MID) ? LENGHT_I : LENGHT_MID)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic [LENGHT_I-1:0][WIDTH-1:0]      x_i,
   input  logic [N_W-1:0][WIDTH_W-1:0]         w_i,
   output logic                                busy,
   output logic                                done,
   output logic [LENGHT_O-1:0][WIDTH-1:0]      y_o
);

   localparam int MAX_IM = (LENGHT_I > LENGHT_MID) ? LENGHT_I : LENGHT_MID;
   localparam int MAXN   = (MAX_IM > LENGHT_O) ? MAX_IM : LENGHT_O;
   localparam int CW     = (MAXN > 1) ? $clog2(MAXN) : 1;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StL1Mac   = 3'd1;
   localparam logic [2:0] StL1Store = 3'd2;
   localparam logic [2:0] StL2Mac   = 3'd3;
   localparam logic [2:0] StL2Store = 3'd4;
   localparam logic [2:0] StDone    = 3'd5;

   logic [2:0]                          state_q, state_d;
   logic [CW-1:0]                       n_q, n_d;
   logic [CW-1:0]                       k_q, k_d;
   logic signed [ACC_W-1:0]             acc_q, acc_d;
   logic [LENGHT_MID-1:0][WIDTH-1:0]    hid_q, hid_d;
   logic [LENGHT_I-1:0][WIDTH-1:0]      x_q, x_d;
   logic [LENGHT_O-1:0][WIDTH-1:0]      y_q, y_d;

   int                                  w_idx;
   logic [WIDTH-1:0]                    opnd;
   logic [WIDTH_W-1:0]                  w_sel;
   logic signed [ACC_W-1:0]             opnd_ext, w_ext, prod;
   logic [WIDTH-1:0]                    act_val;

   // Clamp negative to zero and anything above the WIDTH-bit range to all ones.
   function automatic logic [WIDTH-1:0] act(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      s = a >>> SHIFT;
      if (s[ACC_W-1])               return '0;
      else if (|s[ACC_W-2:WIDTH])   return '1;
      else                          return s[WIDTH-1:0];
   endfunction

   always_comb begin
      if (state_q == StL2Mac) begin
         w_idx = LENGHT_I * LENGHT_MID + int'(n_q) * LENGHT_MID + int'(k_q);
      end else begin
         w_idx = int'(n_q) * LENGHT_I + int'(k_q);
      end

      w_sel = '0;
      for (int j = 0; j < N_W; j++) begin
         if (w_idx == j) w_sel = w_i[j];
      end

      opnd = '0;
      if (state_q == StL2Mac) begin
         for (int j = 0; j < LENGHT_MID; j++) begin
            if (int'(k_q) == j) opnd = hid_q[j];
         end
      end else begin
         for (int j = 0; j < LENGHT_I; j++) begin
            if (int'(k_q) == j) opnd = x_q[j];
         end
      end

      opnd_ext = {{(ACC_W - WIDTH){1'b0}}, opnd};
      w_ext    = {{(ACC_W - WIDTH_W){w_sel[WIDTH_W-1]}}, w_sel};
      prod     = opnd_ext * w_ext;
      act_val  = act(acc_q);
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      k_d     = k_q;
      acc_d   = acc_q;
      hid_d   = hid_q;
      x_d     = x_q;
      y_d     = y_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StL1Mac;
               x_d     = x_i;
               acc_d   = '0;
               n_d     = '0;
               k_d     = '0;
            end
         end
         StL1Mac: begin
            acc_d = acc_q + prod;
            if (k_q == CW'(LENGHT_I - 1)) state_d = StL1Store;
            else                          k_d = k_q + CW'(1);
         end
         StL1Store: begin
            for (int j = 0; j < LENGHT_MID; j++) begin
               if (int'(n_q) == j) hid_d[j] = act_val;
            end
            acc_d = '0;
            k_d   = '0;
            if (n_q == CW'(LENGHT_MID - 1)) begin
               n_d     = '0;
               state_d = StL2Mac;
            end else begin
               n_d     = n_q + CW'(1);
               state_d = StL1Mac;
            end
         end
         StL2Mac: begin
            acc_d = acc_q + prod;
            if (k_q == CW'(LENGHT_MID - 1)) state_d = StL2Store;
            else                            k_d = k_q + CW'(1);
         end
         StL2Store: begin
            for (int j = 0; j < LENGHT_O; j++) begin
               if (int'(n_q) == j) y_d[j] = act_val;
            end
            acc_d = '0;
            k_d   = '0;
            if (n_q == CW'(LENGHT_O - 1)) begin
               state_d = StDone;
            end else begin
               n_d     = n_q + CW'(1);
               state_d = StL2Mac;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         n_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         hid_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         hid_q   <= hid_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign y_o  = y_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer: default build plus a SHIFT=1 build driven
// with the same stimulus.
module tb_mlp_sequencer;

   logic            clk;
   logic            reset;
   logic            start;
   logic [1:0][3:0] x;
   logic [7:0][8:0] w;
   logic            busy0, done0, busy1, done1;
   logic [1:0][3:0] y0, y1;

   int tests = 0;
   int fails = 0;
   int lat, bcnt, dcnt;

   mlp_sequencer dut0 (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .x_i   (x),
      .w_i   (w),
      .busy  (busy0),
      .done  (done0),
      .y_o   (y0)
   );

   mlp_sequencer #(.SHIFT(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .x_i   (x),
      .w_i   (w),
      .busy  (busy1),
      .done  (done1),
      .y_o   (y1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_basic();
      x = '0;
      x[0] = 4'd1;
      x[1] = 4'd3;
      w[0] = 9'd1;   w[1] = 9'd1;   w[2] = 9'd2;   w[3] = 9'd0;
      w[4] = 9'd1;   w[5] = 9'd1;   w[6] = 9'h1FF; w[7] = 9'd3;
   endtask

   // Called on a negedge; returns on the negedge that opens the done cycle.
   task automatic run(input logic [1:0][3:0] x_mid, output int l, output int b);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      l = 1;
      b = 0;
      while (done0 !== 1'b1 && l < 40) begin
         if (busy0 === 1'b1) b++;
         if (l == 2) x = x_mid;
         @(negedge clk);
         l++;
      end
      if (busy0 === 1'b1) b++;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      x     = '0;
      w     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_done", 32'(done0), 32'd0);
      check("rst_y", 32'(y0), 32'h00);
      check("rst_y_shift", 32'(y1), 32'h00);
      reset = 1'b0;
      @(negedge clk);

      // Basic run
      set_basic();
      run(x, lat, bcnt);
      check("basic_latency", 32'(lat), 32'd13);
      check("basic_busy_cycles", 32'(bcnt), 32'd13);
      check("basic_y", 32'(y0), 32'h26);
      check("shift1_y", 32'(y1), 32'h01);
      check("shift1_done", 32'(done1), 32'd1);
      @(negedge clk);
      check("basic_done_one_cycle", 32'(done0), 32'd0);
      check("basic_busy_low", 32'(busy0), 32'd0);

      // Saturation
      x[0] = 4'd15;
      x[1] = 4'd15;
      for (int i = 0; i < 8; i++) w[i] = 9'd1;
      run(x, lat, bcnt);
      check("sat_latency", 32'(lat), 32'd13);
      check("sat_y", 32'(y0), 32'hFF);
      @(negedge clk);

      // ReLU clamps the negative hidden neuron
      x[0] = 4'd1;
      x[1] = 4'd3;
      for (int i = 0; i < 8; i++) w[i] = 9'd1;
      w[0] = 9'h1FF;
      w[1] = 9'h1FF;
      run(x, lat, bcnt);
      check("relu_latency", 32'(lat), 32'd13);
      check("relu_y", 32'(y0), 32'h44);
      @(negedge clk);

      // Start re-pulsed at cycles 3, 12 and during DONE is ignored
      set_basic();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      bcnt = 0;
      dcnt = 0;
      while (done0 !== 1'b1 && lat < 40) begin
         if (busy0 === 1'b1) bcnt++;
         start = (lat == 3 || lat == 12);
         @(negedge clk);
         lat++;
      end
      if (busy0 === 1'b1) bcnt++;
      check("busy_start_latency", 32'(lat), 32'd13);
      check("busy_start_cycles", 32'(bcnt), 32'd13);
      check("busy_start_y", 32'(y0), 32'h26);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_start_ignored_busy", 32'(busy0), 32'd0);
      check("done_start_ignored_done", 32'(done0), 32'd0);

      // Start in first IDLE cycle after done; x changed mid-run has no effect
      x[0] = 4'd0;
      x[1] = 4'd0;
      x = '0;
      set_basic();
      run(8'hFF, lat, bcnt);
      check("rerun_latency", 32'(lat), 32'd13);
      check("rerun_x_snapshot_y", 32'(y0), 32'h26);
      @(negedge clk);

      // Reset mid-operation
      set_basic();
      w[6] = 9'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_busy", 32'(busy0), 32'd0);
      check("midrst_y", 32'(y0), 32'h00);
      check("midrst_done", 32'(done0), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done0 === 1'b1) dcnt++;
         @(negedge clk);
      end
      check("midrst_no_done", 32'(dcnt), 32'd0);
      set_basic();
      run(x, lat, bcnt);
      check("post_rst_latency", 32'(lat), 32'd13);
      check("post_rst_y", 32'(y0), 32'h26);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mlp_sequencer.md
Name: mlp_sequencer

Overview:
- Sequences the two-layer fully connected inference (input -> hidden -> output) using weights held by the manager register block.
- On a start pulse, performs one multiply-accumulate per clock, applies ReLU with saturation per neuron, and buffers hidden-layer results internally.
- Registers the output vector and pulses done when finished.
- Sits between the manager (source of w_o and input values) and the host-visible result registers.

Parameters:
- WIDTH, 4, activation/input/output data width (unsigned)
- WIDTH_W, 9, weight width (signed two's complement)
- LENGHT_I, 2, number of input neurons
- LENGHT_MID, 2, number of hidden neurons
- LENGHT_O, 2, number of output neurons
- SHIFT, 0, arithmetic right shift applied to the accumulator before activation
- N_W, LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O, weight count (derived, do not override)
- ACC_W, WIDTH+WIDTH_W+1+$clog2(max(LENGHT_I,LENGHT_MID)), accumulator width (derived)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin inference; sampled only in IDLE
- x_i  in  [LENGHT_I-1:0][WIDTH-1:0]  input vector, snapshotted on accepted start
- w_i  in  [N_W-1:0][WIDTH_W-1:0]  weights from manager w_o, read live, stable while busy
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when y_o is complete
- y_o  out  [LENGHT_O-1:0][WIDTH-1:0]  registered output vector

Behaviour:
- Reset (synchronous, any state, including mid-run):
  - state=IDLE; counters, accumulator, hidden buffer, x snapshot, y_o all 0; busy=0; done=0.
  - An aborted run never produces done.
- Weight layout:
  - Layer 1, hidden neuron m, input i: index m*LENGHT_I+i.
  - Layer 2, output o, hidden m: index LENGHT_I*LENGHT_MID+o*LENGHT_MID+m.
- States: IDLE, L1_MAC, L1_STORE, L2_MAC, L2_STORE, DONE.
- IDLE:
  - start=1 -> L1_MAC.
  - Snapshot x_i; clear acc, neuron counter n, term counter k.
- L1_MAC:
  - acc += zext(x[k]) * w[n*LENGHT_I+k] (signed).
  - k == LENGHT_I-1 -> L1_STORE; otherwise k++.
- L1_STORE:
  - hid[n]=act(acc); acc=0; k=0.
  - n == LENGHT_MID-1 -> L2_MAC with n=0; otherwise n++ and return to L1_MAC.
- L2_MAC: same as L1_MAC using hid[k] and layer-2 weights; k bound LENGHT_MID-1.
- L2_STORE:
  - y_o[n]=act(acc); acc=0.
  - n == LENGHT_O-1 -> DONE; otherwise n++ and return to L2_MAC.
- DONE: done=1 for exactly this cycle -> IDLE.
- act(a):
  - s = a >>> SHIFT.
  - s<0 -> 0; s>2^WIDTH-1 -> 2^WIDTH-1; else s[WIDTH-1:0].
- Accumulator is ACC_W bits and must never overflow for any legal operands.
- Latency: done is high in cycle 1+LENGHT_MID*(LENGHT_I+1)+LENGHT_O*(LENGHT_MID+1) counted from the start-sampling edge. With defaults, done is high during the 13th cycle after that edge.
- start while busy (including during DONE): ignored, no queuing.
- start in the first IDLE cycle after DONE: accepted normally.
- y_o updates per element at each L2_STORE and otherwise holds its last value.
  - Partially updated y_o is visible while busy.
  - Consumers sample y_o only on done.
- Changes to x_i while busy have no effect.
- Changes to w_i while busy are a protocol violation; result is undefined but the FSM still terminates.

Test Plan:
- Basic run: reset 3 cycles; x=(1,3); w[0..3]=1,1,2,0; w[4..7]=1,1,-1(9'h1FF),3; pulse start -> hid=(4,2), y_o=(6,2), done pulse exactly 13 cycles after the start edge, busy high 13 cycles.
- Saturation: x=(15,15), all w=1 -> hid=(15,15) (raw 30 clipped), y_o=(15,15).
- ReLU: x=(1,3), w[0]=w[1]=-1, others 1 -> hid0=0, hid1=4, y_o=(4,4).
- SHIFT=1 build, basic-run stimulus -> hid=(2,1), y_o=(1,0).
- Start during busy: basic run plus start re-pulsed at cycles 3 and 12 -> single done, y_o=(6,2), busy returns low. Then start on the cycle after done -> second run accepted, done 13 cycles later.
- Reset mid-op: assert reset at cycle 5 of a run -> next cycle busy=0, y_o=(0,0), no done. New start with basic stimulus -> y_o=(6,2).
